// File: rtl/lsu_pkg.sv
// Shared types for the load/store alignment unit.
//   size_e     : access size encoding carried on req_size
//   state_e    : sequencing states of lsu_align
//   size_bytes : number of bytes covered by an access size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int unsigned size_bytes(input size_e sz);
    return 32'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for lsu_align, shared by both bus beats.
// Ports:
//   size, off          access size and byte offset within the bus word
//   unsigned_ld        zero-extend load data when set
//   wdata              right-justified store data
//   rdata_lo/rdata_hi  first / second beat read data (hi is 0 for one beat)
//   be_lo/be_hi        byte enables for the first / second beat
//   wdata_lo/wdata_hi  lane-positioned store data for each beat
//   rdata              merged, extended load data
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned NBYTES = XLEN / 8,
  localparam int unsigned OW = $clog2(NBYTES)
) (
  input  size_e             size,
  input  logic [OW-1:0]     off,
  input  logic              unsigned_ld,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata_lo,
  input  logic [XLEN-1:0]   rdata_hi,
  output logic [NBYTES-1:0] be_lo,
  output logic [NBYTES-1:0] be_hi,
  output logic [XLEN-1:0]   wdata_lo,
  output logic [XLEN-1:0]   wdata_hi,
  output logic [XLEN-1:0]   rdata
);

  logic [2*NBYTES-1:0] be_full;
  logic [2*XLEN-1:0]   wd_full;
  logic [XLEN-1:0]     lanes;
  logic [XLEN-1:0]     keep;
  logic                sign;
  int unsigned         nb;

  // Both beats are handled as one double-width window: the upper half of
  // the shifted enables/data is exactly what the second beat needs.
  always_comb begin
    nb = size_bytes(size);
    if (nb > NBYTES) nb = NBYTES;
    be_full = (2*NBYTES)'((32'd1 << nb) - 32'd1) << off;
    wd_full = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    lanes   = XLEN'({rdata_hi, rdata_lo} >> {off, 3'b000});
    keep    = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (i < nb) keep[8*i +: 8] = 8'hFF;
    end
    // keep & ~(keep >> 1) isolates the most significant kept bit
    sign  = !unsigned_ld && |(lanes & keep & ~(keep >> 1));
    rdata = sign ? (lanes | ~keep) : (lanes & keep);
  end

  assign be_lo    = be_full[NBYTES-1:0];
  assign be_hi    = be_full[2*NBYTES-1:NBYTES];
  assign wdata_lo = wd_full[XLEN-1:0];
  assign wdata_hi = wd_full[2*XLEN-1:XLEN];

endmodule

// File: rtl/lsu_align.sv
// Load/store unit between the MEM stage and the data-memory bus.
// Generates byte enables and lane-shifted store data, merges and extends
// load data, and stalls the pipeline through a req/ack handshake.
// Optional macro LSU_MISALIGN_SPLIT_EN: split misaligned accesses into two
// aligned beats; without it any misaligned access responds with rsp_err.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   req_valid/req_ready                 request handshake from MEM stage
//   req_write/req_size/req_unsigned     access type
//   req_addr/req_wdata                  byte address, right-justified data
//   rsp_valid/rsp_rdata/rsp_err         one-cycle completion pulse + result
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  bus beat, held until mem_ack
//   mem_ack/mem_rdata                   bus completion and read data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OW     = $clog2(NBYTES);

  state_e            state, state_nx;
  logic              r_write, r_unsigned;
  size_e             r_size;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wdata, r_beat1;
  size_e             sz_in;
  logic              accept, bad_size, acc_err, done;
  logic [AW-1:0]     base_addr;
  logic [NBYTES-1:0] be_lo, be_hi;
  logic [XLEN-1:0]   wd_lo, wd_hi, rd_lo, rd_hi, rd_ext;

  assign sz_in     = size_e'(req_size);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign bad_size  = (sz_in == SZ_D) && (XLEN == 32);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic crosses;
  assign acc_err = bad_size;
  assign crosses = (32'(r_addr[OW-1:0]) + size_bytes(r_size)) > NBYTES;
`else
  logic misaligned;
  assign misaligned = (req_addr & AW'(size_bytes(sz_in) - 32'd1)) != '0;
  assign acc_err    = bad_size || misaligned;
`endif

  assign base_addr = {r_addr[AW-1:OW], {OW{1'b0}}};

  // Second beat reuses the lane unit with the first beat's data parked low.
  assign rd_lo = (state == BEAT2) ? r_beat1 : mem_rdata;
  assign rd_hi = (state == BEAT2) ? mem_rdata : '0;

  lsu_lane_align #(.XLEN(XLEN)) u_lane (
    .size        (r_size),
    .off         (r_addr[OW-1:0]),
    .unsigned_ld (r_unsigned),
    .wdata       (r_wdata),
    .rdata_lo    (rd_lo),
    .rdata_hi    (rd_hi),
    .be_lo       (be_lo),
    .be_hi       (be_hi),
    .wdata_lo    (wd_lo),
    .wdata_hi    (wd_hi),
    .rdata       (rd_ext)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = acc_err ? RESP : BEAT1;
      BEAT1: if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
        state_nx = crosses ? BEAT2 : RESP;
`else
        state_nx = RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT2: if (mem_ack) state_nx = RESP;
`endif
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = r_write;
        mem_addr  = base_addr;
        mem_be    = be_lo;
        mem_wdata = wd_lo;
      end
      BEAT2: begin
        mem_req   = 1'b1;
        mem_we    = r_write;
        mem_addr  = base_addr + AW'(NBYTES);
        mem_be    = be_hi;
        mem_wdata = wd_hi;
      end
      default: ;
    endcase
  end

  assign done = ((state == BEAT1) || (state == BEAT2)) && mem_ack
                && (state_nx == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_B;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_beat1    <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= (state_nx == RESP);
      if (accept) begin
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_size     <= sz_in;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        if (acc_err) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if ((state == BEAT1) && mem_ack) r_beat1 <= mem_rdata;
      if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= r_write ? '0 : rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_align #(.XLEN(32), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic             write;
    logic [1:0]       size;
    logic             uns;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [1:0][31:0] rd;
    int               waits;
  } vec_t;

  typedef struct {
    logic             err;
    logic             we;
    int               nb;
    logic [1:0][31:0] addr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wd;
    logic [31:0]      rd;
    int               lat;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  bit   in_beats = 0;
  bit   pending = 0;
  int   beat_idx = 0;
  int   rsp_cyc = 0;
  exp_t cur;
  logic [31:0] last_rd;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] r0, input logic [31:0] r1, input int wt);
    vec_t v;
    v.write = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.rd[0] = r0; v.rd[1] = r1; v.waits = wt;
    return v;
  endfunction

  // Byte-by-byte reference: each byte of the access lands in a bus word and lane.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int unsigned len, a, bi, lane;
    e.err = 1'b0; e.we = v.write; e.nb = 0; e.addr = '0; e.be = '0;
    e.wd = '0; e.rd = '0; e.lat = 1;
    len = 1 << v.size;
    if (v.size == 2'd3) e.err = 1'b1;
    else if ((v.addr % len) != 0 && !SPLIT) e.err = 1'b1;
    if (e.err) return e;
    for (int unsigned k = 0; k < len; k++) begin
      a    = v.addr + k;
      bi   = (a / 4) - (v.addr / 4);
      lane = a % 4;
      e.be[bi][lane] = 1'b1;
      e.wd[bi][8*lane +: 8] = v.wdata[8*k +: 8];
      e.rd[8*k +: 8] = v.rd[bi][8*lane +: 8];
      if (int'(bi) + 1 > e.nb) e.nb = int'(bi) + 1;
    end
    if (!v.uns && len < 4 && e.rd[8*len-1])
      for (int unsigned k = len; k < 4; k++) e.rd[8*k +: 8] = 8'hFF;
    if (v.write) e.rd = '0;
    for (int b = 0; b < 2; b++) begin
      e.addr[b] = (v.addr & 32'hFFFF_FFFC) + 32'(4 * b);
      if (b < e.nb) e.lat += 1 + v.waits;
    end
    return e;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (in_beats) begin
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, cur.addr[beat_idx]);
        check("mem_be", mem_be, cur.be[beat_idx]);
        check("mem_we", mem_we, cur.we);
        check("mem_wdata", mem_wdata & lane_mask(cur.be[beat_idx]), cur.wd[beat_idx]);
        check("req_ready_busy", req_ready, 0);
      end else begin
        check("mem_req_quiet", mem_req, 0);
      end
      check("rsp_valid", rsp_valid, pending && (cyc == rsp_cyc));
      if (rsp_valid && pending) begin
        check("rsp_rdata", rsp_rdata, cur.rd);
        check("rsp_err", rsp_err, cur.err);
        last_rd  = rsp_rdata;
        last_err = rsp_err;
        pending  = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int n;
    cur = model(v);
    last_rd = 32'h5A5A_5A5A; last_err = 1'bx;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = v.write; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    rsp_cyc = cyc + cur.lat;
    pending = 1;
    step();
    req_valid = 0;
    if (cur.nb > 0) in_beats = 1;
    for (int b = 0; b < cur.nb; b++) begin
      beat_idx = b;
      repeat (v.waits) step();
      mem_ack = 1; mem_rdata = v.rd[b];
      step();
      mem_ack = 0; mem_rdata = '0;
    end
    in_beats = 0;
    n = 0;
    while (pending && n < 8) begin step(); n++; end
    if (pending) begin
      check("rsp_timeout", 1, 0);
      pending = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_t m;
    reset = 1; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) step();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 0;
    step();
    chk_en = 1;

    // Hand-computed anchors for the reference model.
    m = model(mk(0, 2'd0, 0, 32'h103, 0, 32'h8000_0000, 0, 0));
    check("model_lb_rd", m.rd, 32'hFFFF_FF80);
    check("model_lb_be", m.be[0], 4'b1000);
    m = model(mk(1, 2'd1, 0, 32'h102, 32'h1234, 0, 0, 0));
    check("model_sh_be", m.be[0], 4'b1100);
    check("model_sh_wd", m.wd[0], 32'h1234_0000);
    m = model(mk(0, 2'd2, 0, 32'h101, 0, 32'h4433_2211, 32'h8877_6655, 0));
    if (SPLIT) begin
      check("model_split_be0", m.be[0], 4'b1110);
      check("model_split_be1", m.be[1], 4'b0001);
      check("model_split_rd", m.rd, 32'h5544_3322);
      check("model_split_lat", m.lat, 3);
    end else begin
      check("model_mis_err", m.err, 1);
    end

    run(mk(0, 2'd2, 0, 32'h100, 0, 32'hDEAD_BEEF, 0, 0));
    check("lw_rdata", last_rd, 32'hDEAD_BEEF);
    check("lw_err", last_err, 0);
    run(mk(0, 2'd0, 0, 32'h103, 0, 32'h8000_0000, 0, 0));
    check("lb_signed", last_rd, 32'hFFFF_FF80);
    run(mk(0, 2'd0, 1, 32'h103, 0, 32'h8000_0000, 0, 0));
    check("lbu", last_rd, 32'h0000_0080);
    run(mk(1, 2'd1, 0, 32'h102, 32'h1234, 0, 0, 0));
    check("sh_rdata", last_rd, 32'h0);
    run(mk(0, 2'd2, 0, 32'h101, 0, 32'h4433_2211, 32'h8877_6655, 0));
    if (SPLIT) check("lw_mis_split", last_rd, 32'h5544_3322);
    else check("lw_mis_err", last_err, 1);
    run(mk(0, 2'd2, 0, 32'h200, 0, 32'h0BAD_F00D, 0, 3));
    check("lw_wait", last_rd, 32'h0BAD_F00D);
    run(mk(0, 2'd1, 0, 32'h106, 0, 32'h8001_0000, 0, 0));
    check("lh_signed", last_rd, 32'hFFFF_8001);
    run(mk(0, 2'd1, 1, 32'h10A, 0, 32'hFFFF_0000, 0, 1));
    check("lhu", last_rd, 32'h0000_FFFF);
    run(mk(1, 2'd0, 0, 32'h101, 32'hAB, 0, 0, 0));
    run(mk(1, 2'd2, 0, 32'h10C, 32'hCAFE_BABE, 0, 0, 2));
    run(mk(0, 2'd3, 0, 32'h108, 0, 32'h1111_1111, 0, 0));
    check("dword_err", last_err, 1);
    check("dword_rdata", last_rd, 32'h0);
    run(mk(0, 2'd1, 0, 32'h103, 0, 32'hAA00_0000, 32'h0000_00BB, 0));
    if (SPLIT) check("lh_cross", last_rd, 32'hFFFF_BBAA);
    else check("lh_cross_err", last_err, 1);
    run(mk(1, 2'd1, 0, 32'h101, 32'h5678, 0, 0, 0));
    run(mk(1, 2'd2, 0, 32'h102, 32'h1122_3344, 0, 0, 1));

    // Reset while the first beat is outstanding: access abandoned, no response.
    cur = model(mk(0, 2'd2, 0, 32'h300, 0, 0, 0, 0));
    req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0;
    req_addr = 32'h300; req_wdata = 0;
    step();
    req_valid = 0; beat_idx = 0; in_beats = 1; pending = 0;
    reset = 1;
    step();
    in_beats = 0; reset = 0;
    check("rst_beat_mem_req", mem_req, 0);
    check("rst_beat_ready", req_ready, 1);
    check("rst_beat_rsp", rsp_valid, 0);
    run(mk(0, 2'd2, 0, 32'h400, 0, 32'h1357_9BDF, 0, 0));
    check("post_reset_lw", last_rd, 32'h1357_9BDF);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
